sr_shift_unit: RTL and testbench

SR_SHIFT_UNIT -- requirements
Module: sr_shift_unit

---
 rtl/sr_shift_unit.sv | 144 ++++++++++++++
 tb/tb_sr_shift_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sr_shift_unit.sv
// sr_shift_unit
// Multi-cycle 32-bit right shifter (logical or arithmetic). Each accepted
// operand is shifted by one barrel stage per cycle, in order 16, 8, 4, 2, 1.
// The result is then held until the consumer takes it.
//
// Parameters
//   EARLY_EXIT : 0 = always run all five stages (fixed 5-cycle latency)
//                1 = finish once no lower shift-amount bits remain set
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   synchronous, active-low reset
//   in_valid  in   operand presented
//   in_ready  out  unit can accept an operand (IDLE only)
//   data_in   in   [31:0] value to shift
//   shamt     in   [4:0]  shift amount
//   arith     in   1 = sra, 0 = srl
//   out_valid out  result available (DONE only)
//   out_ready in   consumer takes result
//   data_out  out  [31:0] result in DONE, zero otherwise
module sr_shift_unit #(
    parameter int EARLY_EXIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] work_r;
    logic [4:0]  shamt_r;
    logic [2:0]  idx_r;
    logic        fill_r;
    // Set on the first edge that samples reset high; keeps in_ready low
    // for the whole time reset is asserted.
    logic        run_r;

    logic        accept;
    logic        last_stage;

    // One barrel stage: stage index 0..4 shifts by 16, 8, 4, 2, 1.
    function automatic logic [31:0] stage_shift(input logic [31:0] v,
                                                input logic [2:0]  idx,
                                                input logic        fill);
        logic [31:0] r;
        r = v;
        case (idx)
            3'd0:    r = {{16{fill}}, v[31:16]};
            3'd1:    r = {{8{fill}},  v[31:8]};
            3'd2:    r = {{4{fill}},  v[31:4]};
            3'd3:    r = {{2{fill}},  v[31:2]};
            3'd4:    r = {fill,       v[31:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Stage index i tests shift-amount bit 4-i.
    function automatic logic stage_bit(input logic [4:0] s, input logic [2:0] idx);
        logic b;
        b = 1'b0;
        case (idx)
            3'd0:    b = s[4];
            3'd1:    b = s[3];
            3'd2:    b = s[2];
            3'd3:    b = s[1];
            3'd4:    b = s[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // True when every shift-amount bit below the one tested at idx is clear.
    function automatic logic lower_clear(input logic [4:0] s, input logic [2:0] idx);
        logic z;
        z = 1'b1;
        case (idx)
            3'd0:    z = (s[3:0] == 4'd0);
            3'd1:    z = (s[2:0] == 3'd0);
            3'd2:    z = (s[1:0] == 2'd0);
            3'd3:    z = ~s[0];
            default: z = 1'b1;
        endcase
        return z;
    endfunction

    assign in_ready  = (state == IDLE) && run_r;
    assign out_valid = (state == DONE);
    assign data_out  = (state == DONE) ? work_r : 32'h0;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_stage = (idx_r == 3'd4) || ((EARLY_EXIT != 0) && lower_clear(shamt_r, idx_r));
        case (state)
            IDLE: begin
                accept = in_valid && run_r;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_stage) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            work_r  <= 32'h0;
            shamt_r <= 5'd0;
            idx_r   <= 3'd0;
            fill_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            run_r <= 1'b1;
            if (accept) begin
                work_r  <= data_in;
                shamt_r <= shamt;
                idx_r   <= 3'd0;
                // Sign is frozen here so later stages never re-read the
                // partially shifted MSB.
                fill_r  <= arith & data_in[31];
            end else if (state == SHIFT) begin
                if (stage_bit(shamt_r, idx_r))
                    work_r <= stage_shift(work_r, idx_r, fill_r);
                idx_r <= idx_r + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sr_shift_unit.sv
// tb_sr_shift_unit
// Directed bench for sr_shift_unit. u_fix uses fixed latency and u_ee uses
// early exit. Both share clock, reset, data_in, shamt, arith and out_ready.
// Each has its own in_valid.
module tb_sr_shift_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        v0, v1;
    logic        ir0, ir1, ov0, ov1;
    logic [31:0] data_in, do0, do1;
    logic [4:0]  shamt;
    logic        arith;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sr_shift_unit #(.EARLY_EXIT(0)) u_fix (
        .clock(clock), .reset(reset), .in_valid(v0), .in_ready(ir0),
        .data_in(data_in), .shamt(shamt), .arith(arith),
        .out_valid(ov0), .out_ready(out_ready), .data_out(do0)
    );

    sr_shift_unit #(.EARLY_EXIT(1)) u_ee (
        .clock(clock), .reset(reset), .in_valid(v1), .in_ready(ir1),
        .data_in(data_in), .shamt(shamt), .arith(arith),
        .out_valid(ov1), .out_ready(out_ready), .data_out(do1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called #1 after an edge with the selected unit idle.
    task automatic run(input int sel, input logic [31:0] d, input logic [4:0] s,
                       input logic a, input logic [31:0] exp, input int exp_lat,
                       input string tag);
        int  lat;
        logic got;
        data_in = d; shamt = s; arith = a;
        if (sel == 0) v0 = 1'b1; else v1 = 1'b1;
        tick();
        v0 = 1'b0; v1 = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            got = (sel == 0) ? ov0 : ov1;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, (sel == 0) ? do0 : do1, exp);
        tick();
        chk({tag, " back to idle"}, (sel == 0) ? {31'd0, ir0} : {31'd0, ir1}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, start, prev;
        logic seen;
        logic [31:0] b2b_d [3];
        logic [4:0]  b2b_s [3];
        logic        b2b_a [3];
        logic [31:0] b2b_e [3];

        reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
        data_in = 32'h0; shamt = 5'd0; arith = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("reset in_ready", {31'd0, ir0}, 32'd0);
        chk("reset out_valid", {31'd0, ov0}, 32'd0);
        chk("reset data_out", do0, 32'h0);
        reset = 1'b1;
        tick();
        chk("ready after release", {31'd0, ir0}, 32'd1);
        chk("ee ready after release", {31'd0, ir1}, 32'd1);

        // Fixed-latency unit: every shift amount takes 5 cycles.
        run(0, 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 5, "sra31");
        run(0, 32'h80000000, 5'd31, 1'b0, 32'h00000001, 5, "srl31");
        run(0, 32'h7FFFFFFF, 5'd4,  1'b1, 32'h07FFFFFF, 5, "sra4 pos");
        run(0, 32'h12345678, 5'd0,  1'b0, 32'h12345678, 5, "shamt0");
        run(0, 32'hF0F0F0F0, 5'd12, 1'b1, 32'hFFFF0F0F, 5, "sra12");
        run(0, 32'hDEADBEEF, 5'd7,  1'b0, 32'h01BD5B7D, 5, "srl7");

        // Result held through back-pressure; inputs ignored meanwhile.
        out_ready = 1'b0;
        data_in = 32'hF0000000; shamt = 5'd8; arith = 1'b1; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 20) begin tick(); lat++; end
        chk("stall latency", lat, 5);
        for (int i = 0; i < 3; i++) begin
            v0 = ~v0; data_in = $urandom; shamt = 5'(i + 1); arith = ~arith;
            tick();
            chk("stall data", do0, 32'hFFF00000);
            chk("stall valid", {31'd0, ov0}, 32'd1);
            chk("stall in_ready", {31'd0, ir0}, 32'd0);
        end
        v0 = 1'b0; out_ready = 1'b1;
        tick();
        chk("stall release valid", {31'd0, ov0}, 32'd0);
        chk("stall release ready", {31'd0, ir0}, 32'd1);
        chk("stall release data", do0, 32'h0);

        // Reset while stage index 2 is being processed.
        data_in = 32'hFFFFFFFF; shamt = 5'd31; arith = 1'b1; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("abort out_valid", {31'd0, ov0}, 32'd0);
        chk("abort in_ready", {31'd0, ir0}, 32'd0);
        tick();
        chk("abort held in_ready", {31'd0, ir0}, 32'd0);
        chk("abort held data", do0, 32'h0);
        reset = 1'b1;
        tick();
        chk("abort release ready", {31'd0, ir0}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | ov0;
        end
        chk("no result after abort", {31'd0, seen}, 32'd0);

        // Early-exit unit: latency depends on the lowest set shift bit.
        run(1, 32'h12345678, 5'd0,  1'b0, 32'h12345678, 1, "ee shamt0");
        run(1, 32'h12345678, 5'd16, 1'b0, 32'h00001234, 1, "ee shamt16");
        run(1, 32'h12345678, 5'd1,  1'b0, 32'h091A2B3C, 5, "ee shamt1");
        run(1, 32'h12345678, 5'd8,  1'b0, 32'h00123456, 2, "ee shamt8");
        run(1, 32'h12345678, 5'd20, 1'b0, 32'h00000123, 3, "ee shamt20");
        run(1, 32'h87654321, 5'd4,  1'b1, 32'hF8765432, 3, "ee sra4");
        run(1, 32'h80000000, 5'd31, 1'b0, 32'h00000001, 5, "ee srl31");

        // Back-to-back with in_valid and out_ready held high.
        b2b_d[0] = 32'hA5A5A5A5; b2b_s[0] = 5'd3;  b2b_a[0] = 1'b1; b2b_e[0] = 32'hF4B4B4B4;
        b2b_d[1] = 32'h0000FFFF; b2b_s[1] = 5'd15; b2b_a[1] = 1'b0; b2b_e[1] = 32'h00000001;
        b2b_d[2] = 32'h80000000; b2b_s[2] = 5'd1;  b2b_a[2] = 1'b1; b2b_e[2] = 32'hC0000000;
        out_ready = 1'b1;
        prev = 0;
        v0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = b2b_d[k]; shamt = b2b_s[k]; arith = b2b_a[k];
            start = 0;
            tick();
            start++;
            while (!ov0 && start < 20) begin tick(); start++; end
            chk("b2b data", do0, b2b_e[k]);
            if (k == 2) v0 = 1'b0;
            if (k > 0) chk("b2b spacing", cyc - prev, 7);
            prev = cyc;
        end
        tick();
        tick();
        chk("b2b final idle", {31'd0, ir0}, 32'd1);
        chk("b2b final valid", {31'd0, ov0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
